// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages: main drives the outputs,
// skid catches one extra entry so in_ready never depends on out_ready.
module pipe_skid_reg #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned TNEW_W   = 2,
    parameter int unsigned TNEW_DEC = 1,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TNEW_W-1:0] in_Tnew,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic [TNEW_W-1:0] out_Tnew,
    output logic [1:0]        out_count,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [DATA_W-1:0] data;
        logic [TNEW_W-1:0] tnew;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam entry_t ENTRY_RST = '{
        pc:    PC_RESET,
        instr: '0,
        data:  '0,
        tnew:  '0
    };

    state_e             state_q, state_d;
    entry_t             main_q, main_d;
    entry_t             skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    entry_t             cap;
    logic               in_fire;
    logic               out_fire;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        cap       = ENTRY_RST;
        cap.pc    = in_pc;
        cap.instr = in_instr;
        cap.data  = in_data;
        cap.tnew  = in_Tnew;
        if (TNEW_DEC == 1 && in_Tnew != '0) begin
            cap.tnew = in_Tnew - TNEW_W'(1);
        end
    end

    // main is returned to the empty pattern whenever the stage drains,
    // so the outputs can be driven straight from main_q.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = cap;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = cap;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = cap;
                end else if (out_fire) begin
                    state_d = EMPTY;
                    main_d  = ENTRY_RST;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = ENTRY_RST;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = ENTRY_RST;
                skid_d  = ENTRY_RST;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = ENTRY_RST;
            skid_d  = ENTRY_RST;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign out_pc    = main_q.pc;
    assign out_instr = main_q.instr;
    assign out_data  = main_q.data;
    assign out_Tnew  = main_q.tnew;
    assign out_count = state_q;
    assign stall_cnt = stall_q;

endmodule
